// File: rtl/cpu_bus_sram_target.sv
// CPU request/ready bus target that splits each 32-bit word access into two
// 16-bit accesses to an asynchronous SRAM, with programmable wait states.
module cpu_bus_sram_target #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ADDR_WIDTH  = 18
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_bus_rw,
  input  logic                  i_bus_request,
  output logic                  o_bus_ready,
  input  logic [31:0]           i_bus_address,
  output logic [31:0]           o_bus_rdata,
  input  logic [31:0]           i_bus_wdata,
  output logic [ADDR_WIDTH-1:0] o_sram_address,
  output logic [15:0]           o_sram_wdata,
  input  logic [15:0]           i_sram_rdata,
  output logic                  o_sram_data_oe,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_we_n
);

  typedef enum logic [3:0] {
    IDLE, RD_LO, RD_HI,
    WR_LO_SETUP, WR_LO_PULSE, WR_LO_HOLD,
    WR_HI_SETUP, WR_HI_PULSE, WR_HI_HOLD,
    DONE, RELEASE
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  state_t                state;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-2:0] word;
  logic [15:0]           rd_lo;
  logic                  wait_done;

  // Byte-lane and out-of-range address bits carry no meaning for this target.
  logic unused_bits;
  assign unused_bits = ^{i_bus_address[31:ADDR_WIDTH+1], i_bus_address[1:0]};

  assign wait_done = (wait_cnt == WAIT_LAST);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      word           <= '0;
      rd_lo          <= '0;
      o_bus_ready    <= 1'b0;
      o_bus_rdata    <= '0;
      o_sram_address <= '0;
      o_sram_wdata   <= '0;
      o_sram_data_oe <= 1'b0;
      o_sram_ce_n    <= 1'b1;
      o_sram_oe_n    <= 1'b1;
      o_sram_we_n    <= 1'b1;
    end else begin
      o_bus_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (i_bus_request) begin
            word           <= i_bus_address[ADDR_WIDTH:2];
            wait_cnt       <= '0;
            o_sram_address <= {i_bus_address[ADDR_WIDTH:2], 1'b0};
            o_sram_ce_n    <= 1'b0;
            if (i_bus_rw) begin
              state          <= WR_LO_SETUP;
              o_sram_data_oe <= 1'b1;
              o_sram_wdata   <= i_bus_wdata[15:0];
            end else begin
              state       <= RD_LO;
              o_sram_oe_n <= 1'b0;
            end
          end
        end
        RD_LO: begin
          if (wait_done) begin
            rd_lo          <= i_sram_rdata;
            wait_cnt       <= '0;
            o_sram_address <= {word, 1'b1};
            state          <= RD_HI;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RD_HI: begin
          if (wait_done) begin
            o_bus_rdata <= {i_sram_rdata, rd_lo};
            o_bus_ready <= 1'b1;
            o_sram_ce_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        WR_LO_SETUP, WR_HI_SETUP: begin
          wait_cnt    <= '0;
          o_sram_we_n <= 1'b0;
          state       <= (state == WR_LO_SETUP) ? WR_LO_PULSE : WR_HI_PULSE;
        end
        WR_LO_PULSE, WR_HI_PULSE: begin
          if (wait_done) begin
            o_sram_we_n <= 1'b1;
            state       <= (state == WR_LO_PULSE) ? WR_LO_HOLD : WR_HI_HOLD;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        WR_LO_HOLD: begin
          // Upper write data is taken only now, as the high half's setup begins.
          o_sram_address <= {word, 1'b1};
          o_sram_wdata   <= i_bus_wdata[31:16];
          state          <= WR_HI_SETUP;
        end
        WR_HI_HOLD: begin
          o_bus_ready    <= 1'b1;
          o_sram_ce_n    <= 1'b1;
          o_sram_data_oe <= 1'b0;
          state          <= DONE;
        end
        DONE: state <= RELEASE;
        RELEASE: begin
          if (!i_bus_request) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_bus_sram_target.md
Name: cpu_bus_sram_target

Overview:
- Bus responder (target) for the CPU request/ready memory bus; sits behind the memory-stage initiator or the dcache bus port.
- Services 32-bit word reads and writes by splitting each access into two sequential 16-bit accesses to an external asynchronous SRAM.
- SRAM timing is met with a programmable number of wait states per half-access.
- Byte and half writes need no support: the initiator performs read-modify-write using full-word accesses.

Parameters:
- WAIT_STATES, 2, extra cycles added to each SRAM read phase and each write-enable pulse (legal range 0..15).
- ADDR_WIDTH, 18, SRAM half-word address width. Bus byte address bits [ADDR_WIDTH:2] select the word; higher bits are ignored.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-low.
- i_bus_rw  in  1  1=write, 0=read; valid while i_bus_request=1.
- i_bus_request  in  1  initiator holds high until it sees o_bus_ready, then drops it.
- o_bus_ready  out  1  single-cycle completion pulse.
- i_bus_address  in  32  byte address; bits [1:0] ignored.
- o_bus_rdata  out  32  read data; valid in the o_bus_ready cycle of a read, held until the next read completes.
- i_bus_wdata  in  32  write data; stable while i_bus_request=1.
- o_sram_address  out  ADDR_WIDTH  half-word address = {i_bus_address[ADDR_WIDTH:2], half}.
- o_sram_wdata  out  16  SRAM write data.
- i_sram_rdata  in  16  SRAM read data.
- o_sram_data_oe  out  1  1 = drive SRAM data pins (top level builds the tristate).
- o_sram_ce_n  out  1  chip enable, active-low.
- o_sram_oe_n  out  1  output enable, active-low.
- o_sram_we_n  out  1  write enable, active-low.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, immediate, also mid-operation):
  - state=IDLE, wait counter=0;
  - o_bus_ready=0, o_bus_rdata=0;
  - o_sram_ce_n=1, o_sram_oe_n=1, o_sram_we_n=1, o_sram_data_oe=0;
  - o_sram_address=0, o_sram_wdata=0.
- Endianness: little-endian. The low half (data[15:0]) is at the even half address (half=0); the high half is at half=1.
- Cycle numbering: cycle 0 is the rising edge at which IDLE samples i_bus_request=1. The address and rw value are latched at that edge. W = WAIT_STATES.
- Each state below holds for the stated number of cycles, counted by the wait counter.
- States:
  - IDLE: ce_n=1, oe_n=1, we_n=1, oe=0. Moves to RD_LO if i_bus_request and !i_bus_rw, or to WR_LO_SETUP if i_bus_request and i_bus_rw.
  - RD_LO: W+1 cycles; ce_n=0, oe_n=0, half=0. In the final cycle, latch i_sram_rdata into rdata[15:0]. Next: RD_HI.
  - RD_HI: W+1 cycles; half=1. In the final cycle, latch i_sram_rdata into rdata[31:16]. Next: DONE.
  - WR_x_SETUP (x = LO or HI): 1 cycle; ce_n=0, we_n=1, oe_n=1, data_oe=1, address and wdata for half x.
  - WR_x_PULSE: W+1 cycles; we_n=0; address and data unchanged.
  - WR_x_HOLD: 1 cycle; we_n=1; address and data still driven. LO is followed by WR_HI_SETUP, HI by DONE.
  - DONE: o_bus_ready=1 for exactly this one cycle. SRAM is deselected (ce_n=1, data_oe=0). Next: RELEASE.
  - RELEASE: o_bus_ready=0. Stays here while i_bus_request=1, then returns to IDLE.
    - A request that deasserts and reasserts in consecutive cycles (RMW pattern) is accepted as a new access.
    - The deassertion is observed in RELEASE and the return to IDLE happens at that edge, so the reasserted request is sampled by IDLE on the following edge.
- Latency:
  - Read: o_bus_ready high in cycle 2W+3 (W=2: cycle 7).
  - Write: o_bus_ready high in cycle 2W+7 (W=2: cycle 11).
- Invariants:
  - o_sram_oe_n=0 and o_sram_we_n=0 are never asserted together.
  - o_sram_data_oe=1 only in WR_* states.
  - o_bus_ready is never high in two consecutive cycles.
- Request dropped before DONE (protocol violation): the access completes and the DONE pulse is still issued. RELEASE then sees request=0 and the block returns to IDLE.
- i_bus_rw and i_bus_address changes after cycle 0 are ignored. i_bus_wdata is sampled at entry to each WR_x_SETUP.

Test Plan:
- Reset low mid-RD_HI (W=2) -> ce_n, oe_n, we_n = 1, data_oe=0, ready=0 in the same cycle without a clock edge; after reset release, a new read completes normally.
- Write 0xDEADBEEF to 0x00000010, W=2 -> SRAM half address 0x08 written 0xBEEF, then 0x09 written 0xDEAD; we_n low for 3 cycles each; o_bus_ready at cycle 11 only.
- Read 0x00000010, SRAM model returns 0xBEEF at 0x08 and 0xDEAD at 0x09 -> o_bus_rdata=0xDEADBEEF, o_bus_ready high in cycle 7 only; o_bus_rdata still 0xDEADBEEF 10 cycles later.
- W=0 read of address 0x0003FFFC with ADDR_WIDTH=18 -> half addresses 0x1FFFE then 0x1FFFF; ready at cycle 3.
- RMW pattern: read, request dropped 1 cycle, write request reasserted -> no spurious ready; write accepted; exactly 2 ready pulses total.
- Initiator holds request 5 cycles after ready -> block stays in RELEASE; no second access started; SRAM stays deselected.
